// File: rtl/field_reg_responder.sv
// Register file responder: read, masked write and masked compare
// with a one-entry response buffer, error counter and write history.
module field_reg_responder #(
  parameter int NREGS = 4,
  parameter int DW    = 8,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_mask,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [7:0]    err_count,
  output logic [DW-1:0] hist_d3
);

  logic [DW-1:0] r_regs [NREGS];
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_rdata;
  logic          r_rsp_err;
  logic [7:0]    r_err_count;
  logic [DW-1:0] r_h1;
  logic [DW-1:0] r_h2;
  logic [DW-1:0] r_h3;

  logic          w_accept;
  logic [DW-1:0] w_cur;
  logic [DW-1:0] w_new;
  logic [DW-1:0] w_rdata;
  logic          w_err;
  logic          w_wr;

  assign req_ready = !r_rsp_valid || rsp_ready;
  assign w_accept  = req_valid && req_ready;

  // Decode the request against the pre-edge register contents.
  always_comb begin
    w_cur   = r_regs[req_addr];
    w_new   = (w_cur & ~req_mask) | (req_wdata & req_mask);
    w_rdata = w_cur;
    w_err   = 1'b0;
    w_wr    = 1'b0;
    unique case (req_op)
      2'b00: w_wr = 1'b0;
      2'b01: w_wr = 1'b1;
      2'b10: w_err = |((w_cur ^ req_wdata) & req_mask);
      default: begin
        w_rdata = '0;
        w_err   = 1'b1;
      end
    endcase
  end

  // Register array: masked writes land on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_accept && w_wr) begin
      r_regs[req_addr] <= w_new;
    end
  end

  // Response buffer: load on accept, drain when consumed, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_rdata <= w_rdata;
      r_rsp_err   <= w_err;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // Error counter bumps once per loaded error response, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (w_accept && w_err && r_err_count != 8'hFF) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  // Three-deep history of post-write values, shifted only by writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h1 <= '0;
      r_h2 <= '0;
      r_h3 <= '0;
    end else if (w_accept && w_wr) begin
      r_h1 <= w_new;
      r_h2 <= r_h1;
      r_h3 <= r_h2;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign err_count = r_err_count;
  assign hist_d3   = r_h3;

endmodule

// File: tb/tb_field_reg_responder.sv
// Randomized and directed bench for field_reg_responder
// against a queue-based behavioural model.
module tb_field_reg_responder;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [1:0] req_addr;
  logic [7:0] req_mask;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [7:0] err_count;
  logic [7:0] hist_d3;

  int n_vec;
  int n_bad;

  logic [7:0] m_regs [4];
  logic       m_valid;
  logic [7:0] m_rdata;
  logic       m_err;
  int         m_cnt;
  logic [7:0] m_hist [$];

  field_reg_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_mask  (req_mask),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .err_count (err_count),
    .hist_d3   (hist_d3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp,
               $time);
    end
  endtask

  function automatic logic [7:0] m_h3();
    return (m_hist.size() >= 3) ? m_hist[2] : 8'h00;
  endfunction

  task automatic model_edge();
    logic [7:0] cur;
    logic [7:0] nv;
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 8'h00;
      m_valid = 1'b0;
      m_rdata = 8'h00;
      m_err   = 1'b0;
      m_cnt   = 0;
      m_hist.delete();
    end else if (req_valid && (!m_valid || rsp_ready)) begin
      cur     = m_regs[req_addr];
      m_valid = 1'b1;
      m_rdata = cur;
      m_err   = 1'b0;
      case (req_op)
        2'd1: begin
          nv = 8'h00;
          for (int b = 0; b < 8; b++)
            nv[b] = req_mask[b] ? req_wdata[b] : cur[b];
          m_regs[req_addr] = nv;
          m_hist.push_front(nv);
          if (m_hist.size() > 3) void'(m_hist.pop_back());
        end
        2'd2: m_err = ((cur & req_mask) != (req_wdata & req_mask));
        2'd3: begin
          m_rdata = 8'h00;
          m_err   = 1'b1;
        end
        default: ;
      endcase
      if (m_err && m_cnt < 255) m_cnt++;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [1:0] op,
                      input logic [1:0] a, input logic [7:0] m,
                      input logic [7:0] d, input logic rr);
    rst       = r;
    req_valid = v;
    req_op    = op;
    req_addr  = a;
    req_mask  = m;
    req_wdata = d;
    rsp_ready = rr;
    #1;
    chk("req_ready", req_ready, !m_valid || rr);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("rsp_valid", rsp_valid, m_valid);
    if (m_valid) begin
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err", rsp_err, m_err);
    end
    chk("err_count", err_count, m_cnt);
    chk("hist_d3", hist_d3, m_h3());
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] m,
                    input logic [7:0] d);
    step(0, 1, 2'd1, a, m, d, 1);
  endtask

  task automatic rd(input logic [1:0] a);
    step(0, 1, 2'd0, a, 8'h00, 8'h00, 1);
  endtask

  task automatic do_reset();
    step(1, 0, 2'd0, 2'd0, 8'h00, 8'h00, 1);
    step(1, 0, 2'd0, 2'd0, 8'h00, 8'h00, 1);
  endtask

  logic [7:0] held;

  initial begin
    n_vec = 0;
    n_bad = 0;
    m_valid = 1'b0;
    m_rdata = 8'h00;
    m_err = 1'b0;
    m_cnt = 0;
    foreach (m_regs[i]) m_regs[i] = 8'h00;
    do_reset();
    chk("rst_valid", rsp_valid, 0);
    chk("rst_cnt", err_count, 0);
    chk("rst_hist", hist_d3, 0);

    wr(2'd0, 8'hFF, 8'h01);
    chk("b2b_wr_v", rsp_valid, 1);
    chk("b2b_wr_rd", rsp_rdata, 8'h00);
    rd(2'd0);
    chk("b2b_rd_v", rsp_valid, 1);
    chk("b2b_rd_rd", rsp_rdata, 8'h01);

    wr(2'd1, 8'h60, 8'h60);
    chk("fb_w1", rsp_rdata, 8'h00);
    wr(2'd1, 8'h10, 8'h10);
    chk("fb_w2", rsp_rdata, 8'h60);
    wr(2'd1, 8'h0C, 8'h08);
    chk("fb_w3", rsp_rdata, 8'h70);
    wr(2'd1, 8'h20, 8'h00);
    chk("fb_w4", rsp_rdata, 8'h78);
    rd(2'd1);
    chk("fb_rd", rsp_rdata, 8'h58);

    step(0, 1, 2'd2, 2'd2, 8'h0F, 8'h03, 1);
    chk("cmp_err", rsp_err, 1);
    chk("cmp_cnt", err_count, 1);
    step(0, 1, 2'd3, 2'd0, 8'h00, 8'h00, 1);
    chk("rsv_err", rsp_err, 1);
    chk("rsv_rd", rsp_rdata, 8'h00);
    chk("rsv_cnt", err_count, 2);

    step(0, 1, 2'd1, 2'd2, 8'hFF, 8'hA5, 1);
    held = rsp_rdata;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 2'd1, 2'd2, 8'hFF, 8'h3C, 0);
      chk("bp_ready", req_ready, 0);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_rdata", rsp_rdata, held);
      chk("bp_cnt", err_count, 2);
    end
    rd(2'd2);
    chk("bp_noacc", rsp_rdata, 8'hA5);

    wr(2'd3, 8'hFF, 8'h11);
    rd(2'd3);
    wr(2'd3, 8'hFF, 8'h22);
    rd(2'd0);
    wr(2'd3, 8'hFF, 8'h33);
    rd(2'd3);
    wr(2'd3, 8'hFF, 8'h44);
    chk("hist", hist_d3, 8'h22);
    rd(2'd3);
    chk("hist_rd", hist_d3, 8'h22);

    for (int i = 0; i < 300; i++)
      step(0, 1, 2'd3, 2'd0, 8'h00, 8'h00, 1);
    chk("sat_cnt", err_count, 255);

    wr(2'd1, 8'hFF, 8'hEE);
    step(0, 1, 2'd1, 2'd2, 8'hFF, 8'h77, 0);
    step(1, 1, 2'd1, 2'd3, 8'hFF, 8'h99, 0);
    chk("mr_valid", rsp_valid, 0);
    chk("mr_rdata", rsp_rdata, 0);
    chk("mr_err", rsp_err, 0);
    chk("mr_cnt", err_count, 0);
    chk("mr_hist", hist_d3, 0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a));
      chk("mr_reg", rsp_rdata, 8'h00);
    end

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)),
           8'($urandom),
           8'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
